lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master_if.sv | 23 ++
 rtl/lsu_bus_master.sv | 109 ++++++++++
 tb/tb_lsu_bus_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_master_if.sv
// Wishbone classic bus between the LSU bus master and a slave.
// Master drives cyc/stb/we/adr/dat/sel; slave answers with dat/ack/err.
interface lsu_bus_master_if;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/lsu_bus_master.sv
// LSU to Wishbone single-access bus master (IDLE -> BUS -> DONE).
// Define LSU_TIMEOUT_EN to abort a BUS phase after TIMEOUT_CYCLES cycles without response.
module lsu_bus_master #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_dat_i,
   input  logic [3:0]  lsu_sel_i,
   input  logic        lsu_we_i,
   input  logic        lsu_re_i,
   output logic [31:0] lsu_dat_o,
   output logic        lsu_stall_o,
   output logic        lsu_done_o,
   output logic        lsu_err_o,
   output logic [1:0]  dbg_state_o,
   lsu_bus_master_if.master wb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

`ifdef LSU_TIMEOUT_EN
   logic [7:0] tmo_cnt;
`endif

   // Handshake: a request (lsu_we_i|lsu_re_i) is taken only in IDLE; the LSU must
   // hold it while lsu_stall_o is high and treats lsu_done_o as completion.
   assign lsu_stall_o = ((state == IDLE) && (lsu_we_i || lsu_re_i)) || (state == BUS);
   assign dbg_state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_adr_o <= 32'd0;
         wb.wb_dat_o <= 32'd0;
         wb.wb_sel_o <= 4'd0;
         lsu_dat_o   <= 32'd0;
         lsu_done_o  <= 1'b0;
         lsu_err_o   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt     <= 8'd0;
`endif
      end else begin
         lsu_done_o <= 1'b0;
         lsu_err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (lsu_we_i || lsu_re_i) begin
                  wb.wb_adr_o <= lsu_addr_i;
                  wb.wb_dat_o <= lsu_dat_i;
                  wb.wb_we_o  <= lsu_we_i;
                  wb.wb_sel_o <= lsu_we_i ? lsu_sel_i : 4'b1111;
                  wb.wb_cyc_o <= 1'b1;
                  wb.wb_stb_o <= 1'b1;
                  state       <= BUS;
`ifdef LSU_TIMEOUT_EN
                  tmo_cnt     <= 8'd0;
`endif
               end
            end
            BUS: begin
               // err is checked first so a simultaneous ack never updates read data
               if (wb.wb_err_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  lsu_done_o  <= 1'b1;
                  lsu_err_o   <= 1'b1;
                  state       <= DONE;
               end else if (wb.wb_ack_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  lsu_done_o  <= 1'b1;
                  if (!wb.wb_we_o) lsu_dat_o <= wb.wb_dat_i;
                  state       <= DONE;
               end
`ifdef LSU_TIMEOUT_EN
               // counter reads N-1 during the Nth BUS cycle
               else if (tmo_cnt == TIMEOUT_CYCLES - 8'd1) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  lsu_done_o  <= 1'b1;
                  lsu_err_o   <= 1'b1;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: vector table of single accesses plus
// hand sequences for reset, DONE-cycle requests, stray acks and bus timeout.
module tb_lsu_bus_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_dat_i;
   logic [3:0]  lsu_sel_i;
   logic        lsu_we_i;
   logic        lsu_re_i;
   logic [31:0] lsu_dat_o;
   logic        lsu_stall_o;
   logic        lsu_done_o;
   logic        lsu_err_o;
   logic [1:0]  dbg_state_o;

   lsu_bus_master_if wb ();

   lsu_bus_master #(.TIMEOUT_CYCLES(8'd4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .lsu_addr_i  (lsu_addr_i),
      .lsu_dat_i   (lsu_dat_i),
      .lsu_sel_i   (lsu_sel_i),
      .lsu_we_i    (lsu_we_i),
      .lsu_re_i    (lsu_re_i),
      .lsu_dat_o   (lsu_dat_o),
      .lsu_stall_o (lsu_stall_o),
      .lsu_done_o  (lsu_done_o),
      .lsu_err_o   (lsu_err_o),
      .dbg_state_o (dbg_state_o),
      .wb          (wb.master)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2;
   localparam logic [1:0] RSP_ACK = 2'd0, RSP_ERR = 2'd1, RSP_BOTH = 2'd2;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] sdat;
      int          wait_st;
      logic [1:0]  rsp;
      logic        exp_we;
      logic [3:0]  exp_sel;
      logic [31:0] exp_rdat;
      logic        exp_err;
      int          exp_done;
   } vec_t;

   vec_t vecs[7];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      lsu_we_i = 1'b0;
      lsu_re_i = 1'b0;
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int c;
      bit seen;
      @(negedge clk_i);
      lsu_we_i = v.we;
      lsu_re_i = v.re;
      lsu_addr_i = v.addr;
      lsu_dat_i = v.wdat;
      lsu_sel_i = v.sel;
      #1 check("stall_c0", lsu_stall_o, 1);
      seen = 0;
      c = 0;
      while (!seen && c < 40) begin
         @(negedge clk_i);
         c++;
         idle_inputs();
         #1;
         if (lsu_done_o) begin
            seen = 1;
            check("done_cycle", c, v.exp_done);
            check("err", lsu_err_o, v.exp_err);
            check("rdat", lsu_dat_o, v.exp_rdat);
            check("cyc_done", wb.wb_cyc_o, 0);
            check("stall_done", lsu_stall_o, 0);
            check("state_done", dbg_state_o, S_DONE);
         end else begin
            check("stall_bus", lsu_stall_o, 1);
            check("cyc_bus", wb.wb_cyc_o, 1);
            if (c == 1) begin
               check("stb", wb.wb_stb_o, 1);
               check("we", wb.wb_we_o, v.exp_we);
               check("sel", wb.wb_sel_o, v.exp_sel);
               check("adr", wb.wb_adr_o, v.addr);
               if (v.exp_we) check("wdat", wb.wb_dat_o, v.wdat);
            end
            if (c == 1 + v.wait_st) begin
               wb.wb_dat_i = v.sdat;
               wb.wb_ack_i = (v.rsp != RSP_ERR);
               wb.wb_err_i = (v.rsp != RSP_ACK);
            end
         end
      end
      if (!seen) check("done_timeout", 0, 1);
      @(negedge clk_i);
      #1;
      check("done_pulse_end", lsu_done_o, 0);
      check("err_pulse_end", lsu_err_o, 0);
      check("state_idle", dbg_state_o, S_IDLE);
   endtask

   initial begin
      //        we re addr        wdat          sel     sdat          ws rsp       ewe esel    erdat         eerr edone
      vecs[0] = '{1, 0, 32'h100, 32'hAABBCCDD, 4'b0011, 32'h0,        0, RSP_ACK,  1, 4'b0011, 32'h0,        0, 2};
      vecs[1] = '{0, 1, 32'h200, 32'h0,        4'b0000, 32'h12345678, 3, RSP_ACK,  0, 4'b1111, 32'h12345678, 0, 5};
      vecs[2] = '{1, 1, 32'h300, 32'h11223344, 4'b1100, 32'hDEADBEEF, 1, RSP_ACK,  1, 4'b1100, 32'h12345678, 0, 3};
      vecs[3] = '{0, 1, 32'h400, 32'h0,        4'b0101, 32'hCAFEF00D, 2, RSP_BOTH, 0, 4'b1111, 32'h12345678, 1, 4};
      vecs[4] = '{0, 1, 32'h500, 32'h0,        4'b0000, 32'h5555AAAA, 0, RSP_ERR,  0, 4'b1111, 32'h12345678, 1, 2};
      vecs[5] = '{0, 1, 32'h600, 32'h0,        4'b0000, 32'h0BADF00D, 1, RSP_ACK,  0, 4'b1111, 32'h0BADF00D, 0, 3};
      vecs[6] = '{1, 0, 32'h700, 32'h01020304, 4'b1000, 32'h77777777, 0, RSP_ERR,  1, 4'b1000, 32'h0BADF00D, 1, 2};

      // clock/reset
      rst_i = 1'b1;
      lsu_addr_i = 32'h0;
      lsu_dat_i = 32'h0;
      lsu_sel_i = 4'h0;
      wb.wb_dat_i = 32'h0;
      idle_inputs();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_state", dbg_state_o, S_IDLE);
      check("rst_cyc", wb.wb_cyc_o, 0);
      check("rst_stb", wb.wb_stb_o, 0);
      check("rst_we", wb.wb_we_o, 0);
      check("rst_adr", wb.wb_adr_o, 0);
      check("rst_wdat", wb.wb_dat_o, 0);
      check("rst_sel", wb.wb_sel_o, 0);
      check("rst_rdat", lsu_dat_o, 0);
      check("rst_done", lsu_done_o, 0);
      check("rst_err", lsu_err_o, 0);
      check("rst_stall", lsu_stall_o, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // stray ack/err in IDLE must be ignored
      @(negedge clk_i);
      wb.wb_ack_i = 1'b1;
      wb.wb_err_i = 1'b1;
      wb.wb_dat_i = 32'hFFFF0000;
      repeat (2) begin
         @(negedge clk_i);
         #1;
         check("stray_done", lsu_done_o, 0);
         check("stray_err", lsu_err_o, 0);
         check("stray_state", dbg_state_o, S_IDLE);
         check("stray_rdat", lsu_dat_o, 32'h0BADF00D);
      end
      idle_inputs();

      // request held through DONE is taken only once back in IDLE
      @(negedge clk_i);
      lsu_re_i = 1'b1;
      lsu_addr_i = 32'h900;
      @(negedge clk_i);
      idle_inputs();
      wb.wb_dat_i = 32'h55AA55AA;
      wb.wb_ack_i = 1'b1;
      @(negedge clk_i);
      wb.wb_ack_i = 1'b0;
      lsu_re_i = 1'b1;
      lsu_addr_i = 32'hA00;
      #1;
      check("dq_done", lsu_done_o, 1);
      check("dq_state", dbg_state_o, S_DONE);
      check("dq_stall_done", lsu_stall_o, 0);
      check("dq_rdat", lsu_dat_o, 32'h55AA55AA);
      @(negedge clk_i);
      #1;
      check("dq_state_idle", dbg_state_o, S_IDLE);
      check("dq_cyc_idle", wb.wb_cyc_o, 0);
      check("dq_stall_idle", lsu_stall_o, 1);
      @(negedge clk_i);
      idle_inputs();
      #1;
      check("dq_cyc_bus", wb.wb_cyc_o, 1);
      check("dq_adr", wb.wb_adr_o, 32'hA00);
      wb.wb_dat_i = 32'h600DCAFE;
      wb.wb_ack_i = 1'b1;
      @(negedge clk_i);
      idle_inputs();
      #1;
      check("dq2_done", lsu_done_o, 1);
      check("dq2_rdat", lsu_dat_o, 32'h600DCAFE);

      // slave never answers
      @(negedge clk_i);
      lsu_re_i = 1'b1;
      lsu_addr_i = 32'hB00;
      @(negedge clk_i);
      idle_inputs();
`ifdef LSU_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         #1;
         check("tmo_cyc", wb.wb_cyc_o, 1);
         check("tmo_no_done", lsu_done_o, 0);
         @(negedge clk_i);
      end
      #1;
      check("tmo_cyc_drop", wb.wb_cyc_o, 0);
      check("tmo_stb_drop", wb.wb_stb_o, 0);
      check("tmo_done", lsu_done_o, 1);
      check("tmo_err", lsu_err_o, 1);
      check("tmo_rdat", lsu_dat_o, 32'h600DCAFE);
      @(negedge clk_i);
      #1;
      check("tmo_done_end", lsu_done_o, 0);
      check("tmo_state", dbg_state_o, S_IDLE);
`else
      for (int c = 1; c <= 30; c++) begin
         #1;
         check("wait_cyc", wb.wb_cyc_o, 1);
         check("wait_no_done", lsu_done_o, 0);
         @(negedge clk_i);
      end
      wb.wb_ack_i = 1'b1;
      wb.wb_dat_i = 32'h13579BDF;
      @(negedge clk_i);
      idle_inputs();
      #1;
      check("wait_done", lsu_done_o, 1);
      check("wait_err", lsu_err_o, 0);
      check("wait_rdat", lsu_dat_o, 32'h13579BDF);
      @(negedge clk_i);
`endif

      // reset during BUS, then a late ack
      @(negedge clk_i);
      lsu_we_i = 1'b1;
      lsu_addr_i = 32'hC00;
      lsu_dat_i = 32'h0F0F0F0F;
      lsu_sel_i = 4'b1111;
      @(negedge clk_i);
      idle_inputs();
      #1;
      check("rb_cyc_bus", wb.wb_cyc_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rb_cyc", wb.wb_cyc_o, 0);
      check("rb_stb", wb.wb_stb_o, 0);
      check("rb_state", dbg_state_o, S_IDLE);
      check("rb_rdat", lsu_dat_o, 0);
      wb.wb_ack_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         #1;
         check("rb_no_done", lsu_done_o, 0);
         check("rb_no_err", lsu_err_o, 0);
         check("rb_cyc_late", wb.wb_cyc_o, 0);
         check("rb_state_late", dbg_state_o, S_IDLE);
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
